// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-sequencer state encoding.
// No logic; types and constants only.
// Used by the register file and its write-port arbiter.
package regfile_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_REGS   = 2 ** RF_ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_write_arbiter_dbg_buffer.sv
// One-entry debug write buffer with starvation counter and core-stall request.
// Latency: accepted entry is visible on buf_* from the next cycle.
// Backpressure: dbg_ready low while an entry is pending; starve forces the core to stall.
module dbg_write_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  dbg_valid,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  input  logic                  issue,
  output logic                  dbg_ready,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [DATA_WIDTH-1:0] buf_data,
  output logic                  starve
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

  logic [WW-1:0] wait_cnt;
  logic          accept;

  assign dbg_ready = run && !pending;
  assign accept    = dbg_valid && dbg_ready;
  assign starve    = run && pending && (wait_cnt == LIMIT);

  // Buffer capture, pending flag and saturating wait counter (frozen outside RUN).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= 1'b0;
      wait_cnt <= '0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (issue) begin
      pending <= 1'b0;
    end else if (accept) begin
      pending  <= 1'b1;
      wait_cnt <= '0;
      buf_addr <= dbg_addr;
      buf_data <= dbg_data;
    end else if (run && pending && (wait_cnt != LIMIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer/arbiter: clears x1..x31, then shares we3 between core and debug.
// Latency: zero for core writes; debug writes issue 1..STARVE_LIMIT+1 cycles after acceptance.
// Backpressure: stall_core during clear or debug starvation; dbg_ready while buffer empty.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = RF_ADDR_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_data,
  input  logic                  clr_req,
  input  logic                  dbg_valid,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  dbg_ready,
  output logic                  stall_core,
  output logic                  busy,
  output logic                  we3,
  output logic [ADDR_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0] wd3
);

  localparam logic [ADDR_WIDTH-1:0] CLR_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = {ADDR_WIDTH{1'b1}};

  rf_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic                  run;
  logic                  pending, starve, issue, core_sel;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_data;

  assign run        = (state == ST_RUN);
  assign busy       = !run;
  assign stall_core = !run || starve;

  // A starving buffer pre-empts the core; otherwise the core wins and the buffer fills idle slots.
  assign issue    = run && (starve || (!core_we && pending));
  assign core_sel = run && !starve && core_we;

  dbg_write_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_dbg_buf (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .dbg_valid(dbg_valid),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .issue    (issue),
    .dbg_ready(dbg_ready),
    .pending  (pending),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .starve   (starve)
  );

  // State and clear-pointer registers; reset restarts the clear sequence at x1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_INIT;
      clr_cnt <= CLR_FIRST;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state: walk the clear pointer in INIT, re-enter INIT on clr_req in RUN.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == ST_INIT) begin
      clr_cnt_nxt = clr_cnt + 1'b1;
      if (clr_cnt == CLR_LAST) state_nxt = ST_RUN;
    end else if (clr_req) begin
      state_nxt   = ST_INIT;
      clr_cnt_nxt = CLR_FIRST;
    end
  end

  // Write-port mux; x0 writes are swallowed and idle address/data are held at zero.
  always_comb begin
    we3 = 1'b0;
    A3  = '0;
    wd3 = '0;
    if (rst) begin
      if (!run) begin
        we3 = 1'b1;
        A3  = clr_cnt;
      end else if (issue) begin
        if (buf_addr != '0) begin
          we3 = 1'b1;
          A3  = buf_addr;
          wd3 = buf_data;
        end
      end else if (core_sel) begin
        if (core_addr != '0) begin
          we3 = 1'b1;
          A3  = core_addr;
          wd3 = core_data;
        end
      end
    end
  end

endmodule
